// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, double-buffered duty levels.
// Centre-aligned counting is built only when PWM_MULTI_CENTER_EN is defined.
module pwm_multi #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned PRESCALE_W = 4,
  parameter bit          INVERT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      center,
  input  logic [CHANNELS*WIDTH-1:0] level,
  input  logic                      level_load,
  output logic                      pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       out
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

`ifdef PWM_MULTI_CENTER_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;

  dir_e  dir_q, dir_d;
  mode_e mode_q, mode_d;
`else
  logic center_unused;
  assign center_unused = center;
`endif

  logic [PRESCALE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic [CHANNELS*WIDTH-1:0] active_q, active_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic                      pending_q, pending_d;
  logic                      period_start_q, period_start_d;
  logic [CHANNELS-1:0]       out_q, out_d;
  logic                      tick;

  always_comb begin
    // >= so that lowering prescale mid-count ticks at once instead of running to wrap
    tick           = (pre_cnt_q >= prescale);
    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    count_d        = count_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    period_start_d = 1'b0;
    out_d          = '0;
`ifdef PWM_MULTI_CENTER_EN
    dir_d  = dir_q;
    mode_d = mode_q;
    if (tick) begin
      if (mode_q == MODE_CENTER) begin
        if (dir_q == DIR_DOWN) begin
          count_d = count_q - 1'b1;
        end else if (count_q == CNT_MAX) begin
          count_d = count_q - 1'b1;
          dir_d   = DIR_DOWN;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
`else
    if (tick) count_d = count_q + 1'b1;
`endif

    if (tick && (count_d == '0)) begin
      period_start_d = 1'b1;
      if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
`ifdef PWM_MULTI_CENTER_EN
      dir_d  = DIR_UP;
      mode_d = center ? MODE_CENTER : MODE_EDGE;
`endif
    end

    // A load on the period-start edge lands in the shadow after the old shadow was applied
    if (level_load) begin
      shadow_d  = level;
      pending_d = 1'b1;
    end

    for (int unsigned n = 0; n < CHANNELS; n++) begin
      out_d[n] = (count_q < active_q[n*WIDTH +: WIDTH]) ^ INVERT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q      <= '0;
      count_q        <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
      out_q          <= '0;
`ifdef PWM_MULTI_CENTER_EN
      dir_q          <= DIR_UP;
      mode_q         <= MODE_EDGE;
`endif
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      count_q        <= count_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
`ifdef PWM_MULTI_CENTER_EN
      dir_q          <= dir_d;
      mode_q         <= mode_d;
`endif
    end
  end

  assign pending      = pending_q;
  assign period_start = period_start_q;
  assign out          = out_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-position model checked every cycle, plus hand-computed window counts.
module tb_pwm_multi;

`ifdef PWM_MULTI_CENTER_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  prescale = '0;
  logic        center = 1'b0;
  logic [23:0] level = '0;
  logic        level_load = 1'b0;
  logic        pending, period_start, pending_i, period_start_i;
  logic [2:0]  out, out_i;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(8), .CHANNELS(3), .PRESCALE_W(4), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .center(center),
    .level(level), .level_load(level_load),
    .pending(pending), .period_start(period_start), .out(out)
  );

  pwm_multi #(.WIDTH(8), .CHANNELS(3), .PRESCALE_W(4), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .prescale(prescale), .center(center),
    .level(level), .level_load(level_load),
    .pending(pending_i), .period_start(period_start_i), .out(out_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the period; the count is derived from position and mode.
  int         m_pre, m_pos;
  bit         m_mode;
  int         m_act[3];
  int         m_sh[3];
  bit         m_pend, m_ps;
  logic [2:0] m_out, m_out_inv;

  function automatic int cnt_of(int pos, bit mode);
    if (mode && pos > 255) return 510 - pos;
    return pos;
  endfunction

  function automatic int plen(bit mode);
    return mode ? 510 : 256;
  endfunction

  always @(posedge clk) begin : model
    int         c;
    bit         tk;
    logic [2:0] on;
    if (reset) begin
      m_pre = 0; m_pos = 0; m_mode = 0; m_pend = 0; m_ps = 0;
      for (int n = 0; n < 3; n++) begin m_act[n] = 0; m_sh[n] = 0; end
      m_out = '0; m_out_inv = '0;
    end else begin
      c = cnt_of(m_pos, m_mode);
      for (int n = 0; n < 3; n++) on[n] = (c < m_act[n]);
      m_out = on;
      m_out_inv = ~on;
      tk = (m_pre >= int'(prescale));
      m_pre = tk ? 0 : m_pre + 1;
      m_ps = 0;
      if (tk) begin
        m_pos = (m_pos + 1) % plen(m_mode);
        if (m_pos == 0) begin
          m_ps = 1;
          if (m_pend) m_act = m_sh;
          m_pend = 0;
          m_mode = CEN && center;
        end
      end
      if (level_load) begin
        for (int n = 0; n < 3; n++) m_sh[n] = int'(level[n*8 +: 8]);
        m_pend = 1;
      end
    end
    #1;
    check("cyc_out", 32'(out), 32'(m_out));
    check("cyc_pending", 32'(pending), 32'(m_pend));
    check("cyc_period_start", 32'(period_start), 32'(m_ps));
    check("cyc_inv", {28'd0, pending_i, period_start_i, out_i}, {28'd0, m_pend, m_ps, m_out_inv});
  end

  int   hi[3];
  int   ps_idx, ps_n;
  logic pend_mid, pend_end;

  // Sample n_cyc cycles (i=0 is the cycle after the call); optional input events at given indices.
  task automatic measure(input int n_cyc,
                         input int l1_at, input logic [23:0] l1_v,
                         input int l2_at, input logic [23:0] l2_v,
                         input int p_at, input logic [3:0] p_v,
                         input int c_at, input logic c_v);
    for (int c = 0; c < 3; c++) hi[c] = 0;
    ps_idx = -1; ps_n = 0; pend_mid = 1'b0; pend_end = 1'b0;
    for (int i = 0; i < n_cyc; i++) begin
      @(posedge clk); #1;
      level_load = 1'b0;
      for (int c = 0; c < 3; c++) if (out[c] === 1'b1) hi[c]++;
      if (period_start === 1'b1) begin
        ps_n++;
        if (ps_idx < 0) ps_idx = i;
      end
      if (i == n_cyc / 2) pend_mid = pending;
      if (i == n_cyc - 1) pend_end = pending;
      if (i == l1_at) begin level = l1_v; level_load = 1'b1; end
      if (i == l2_at) begin level = l2_v; level_load = 1'b1; end
      if (i == p_at) prescale = p_v;
      if (i == c_at) center = c_v;
    end
  endtask

  task automatic chk_win(input string tag, input int e0, input int e1, input int e2, input int eps);
    check({tag, "_hi0"}, hi[0], e0);
    check({tag, "_hi1"}, hi[1], e1);
    check({tag, "_hi2"}, hi[2], e2);
    check({tag, "_ps_idx"}, ps_idx, eps);
    check({tag, "_ps_n"}, ps_n, 1);
  endtask

  task automatic wait_ps(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(posedge clk); #1;
      level_load = 1'b0;
      if (period_start === 1'b1) seen = 1'b1;
    end
    check("wait_ps", 32'(seen), 32'd1);
  endtask

  initial begin : stim
    int found, bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_inv", 32'(out_i), 32'd0);
    reset = 1'b0;

    level = {8'd255, 8'd0, 8'd64};
    level_load = 1'b1;
    @(posedge clk); #1;
    level_load = 1'b0;
    check("load_pending", 32'(pending), 32'd1);
    check("inv_level0", 32'(out_i), 32'd7);
    wait_ps(3000);
    check("applied_pending", 32'(pending), 32'd0);

    measure(256, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("edge", 64, 0, 255, 255);

    measure(256, 49, {8'd255, 8'd0, 8'd128}, -1, '0, -1, '0, -1, 1'b0);
    chk_win("midload_cur", 64, 0, 255, 255);
    check("midload_pend_mid", 32'(pend_mid), 32'd1);
    check("midload_pend_end", 32'(pend_end), 32'd0);
    measure(256, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("midload_next", 128, 0, 255, 255);

    measure(256, 100, {8'd255, 8'd0, 8'd10}, 254, {8'd255, 8'd0, 8'd20}, -1, '0, -1, 1'b0);
    chk_win("pslоad_a", 128, 0, 255, 255);
    check("psload_pend_end", 32'(pend_end), 32'd1);
    measure(256, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("psload_b", 10, 0, 255, 255);
    check("psload_b_pend_end", 32'(pend_end), 32'd0);
    measure(256, 10, {8'd255, 8'd0, 8'd64}, -1, '0, -1, '0, -1, 1'b0);
    chk_win("psload_c", 20, 0, 255, 255);

    prescale = 4'd3;
    measure(1024, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("pre3", 256, 0, 1020, 1023);
    measure(258, -1, '0, -1, '0, 1, 4'd0, -1, 1'b0);
    chk_win("pre3to0", 66, 0, 257, 257);

    measure(256, 10, {8'd255, 8'd0, 8'd100}, -1, '0, -1, '0, 20, 1'b1);
    chk_win("pre_centre", 64, 0, 255, 255);
`ifdef PWM_MULTI_CENTER_EN
    measure(510, -1, '0, -1, '0, -1, '0, 100, 1'b0);
    chk_win("centre", 199, 0, 509, 509);
`else
    measure(256, -1, '0, -1, '0, -1, '0, 100, 1'b0);
    chk_win("centre_off", 100, 0, 255, 255);
`endif
    measure(256, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("back_edge", 100, 0, 255, 255);

    measure(100, 50, {8'd255, 8'd0, 8'd30}, -1, '0, -1, '0, -1, 1'b0);
    check("pend_before_rst", 32'(pending), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_out_inv", 32'(out_i), 32'd0);
    check("midrst_period_start", 32'(period_start), 32'd0);
    reset = 1'b0;
    found = -1;
    bad = 0;
    for (int k = 1; k <= 600 && found < 0; k++) begin
      @(posedge clk); #1;
      if (out_i !== 3'b111) bad++;
      if (period_start === 1'b1) found = k;
    end
    check("rst_restart_period", found, 256);
    check("inv_const_high", bad, 0);
    measure(256, -1, '0, -1, '0, -1, '0, -1, 1'b0);
    chk_win("rst_discard", 0, 0, 0, 255);
    check("rst_discard_pend", 32'(pend_end), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator, parametrised successor to the single-channel 8-bit PWM. Drives CHANNELS outputs from one shared period counter with a programmable clock prescaler, optional centre-aligned counting, and double-buffered duty levels that update only at a period boundary, so outputs never glitch. Sits between the register/encoder front end and the LED/output pins.

## Interface
- WIDTH, 8: counter and level width in bits.
- CHANNELS, 3: number of PWM outputs.
- PRESCALE_W, 4: prescaler control width.
- INVERT, 0: 1 inverts every channel output outside reset.

- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- prescale  input  PRESCALE_W  counter advances once every prescale+1 clk cycles.
- center  input  1  mode request: 0 edge-aligned, 1 centre-aligned; sampled at period start.
- level  input  CHANNELS*WIDTH  new duty levels; channel n at bits [n*WIDTH +: WIDTH].
- level_load  input  1  one-cycle strobe capturing level into the shadow registers.
- pending  output  1  shadow holds levels not yet applied.
- period_start  output  1  one-cycle pulse marking the first tick of a period.
- out  output  CHANNELS  PWM outputs.

## Operation
- Prescaler: pre_cnt counts up each clk; tick = (pre_cnt >= prescale), and pre_cnt clears to 0 on tick. The >= compare makes a mid-count decrease of prescale tick immediately instead of hanging.
- Edge mode: on each tick, count goes 0 → 2^WIDTH-1, then wraps to 0. Period is 2^WIDTH ticks.
- Centre mode: on each tick, count goes 0 up to 2^WIDTH-1, then down to 1, then 0. Direction flips on reaching max and on reaching 0. Period is 2*(2^WIDTH-1) ticks.
- Period start: the tick on which count becomes 0. On that clk edge:
  - active levels ← shadow, if pending;
  - active mode ← center;
  - period_start ← 1 for one cycle.
- Shadow: level_load writes shadow ← level and sets pending ← 1. A load while pending overwrites the shadow (last write wins). At period start, pending clears unless level_load is asserted on the same edge.
- Load on the same edge as period start: the old shadow is applied. The new level goes to the shadow, pending stays 1, and the new value is applied at the next period start.
- Per-channel output: on = (count < active_level[n]); out[n] ← INVERT ? !on : on.
  - Level 0 gives constant off.
  - Level 2^WIDTH-1 gives high for all but one tick per period in edge mode.
- Counter and comparisons are unsigned, WIDTH bits, with no saturation logic.

## Timing
- Reset values: count 0, direction up, pre_cnt 0, active levels 0, shadow 0, mode edge, pending 0, period_start 0, out all 0. out is forced to 0 during reset regardless of INVERT.
- out is registered: it reflects count and active levels from the previous cycle, so there is 1 clk latency from a count change to an out change.
- period_start is asserted in the cycle where count first reads 0 of the new period.
- pending rises 1 clk after level_load.
- New levels affect out starting 1 clk after period_start.
- Reset asserted mid-period: all state returns to reset values on that edge and any pending shadow is discarded. The first post-reset cycle restarts at count 0, but no period_start pulse is issued for it.
- center changes mid-period are ignored until the next period start.

## Configuration
- PWM_MULTI_CENTER_EN defined:
  - centre-aligned mode is available;
  - direction register and mode latch are implemented.
- PWM_MULTI_CENTER_EN undefined:
  - center is ignored;
  - counter is always edge-aligned;
  - no direction or mode logic is synthesised;
  - all other behaviour is identical.

## Test plan
- Edge mode, WIDTH=8, prescale=0, load level ch0=64, ch1=0, ch2=255, after one full period: per 256 clk, ch0 high 64 cycles, ch1 never high, ch2 high 255 cycles; period_start every 256 clk.
- Load ch0=128 at count 50 while active=64: pending=1 until the next period_start; the current period still shows 64 high cycles; the next period shows 128; pending then drops to 0.
- Prescale=3, level 64: period_start every 1024 clk; out high 256 clk per period. Change prescale 3→0 while pre_cnt=2: tick occurs on the next edge, then every clk.
- Centre mode (macro defined), level 100: period 510 clk; out high 199 clk per period in one contiguous pulse spanning the count-0 point. With the macro undefined, the same stimulus gives 256-clk periods with 100 high cycles.
- level_load on the period_start edge with shadow=10, new=20: the period uses 10, pending stays 1, and the following period uses 20.
- INVERT=1, level 0: out held at 0 during reset, then constant 1. Assert reset mid-period after a load: pending=0, out=0 during reset, and count restarts at 0.
